alu_arbiter: RTL

- Shares the single combinational ALU between two requesters: req0 is decode/execute and req1 is an auxiliary unit, for example the address-generation or debug path.
- Round-robin arbitration with valid/ready handshakes on both request and response sides.
- Results are registered per requester, so each requester sees a one-cycle, back-pressurable response channel.
- Sits between requesters and the ALU; the ALU's enable, operator and operands are driven from this block.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operator encoding shared by the ALU and its arbiter
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLTS = 4'd5,
        ALU_SLTU = 4'd6
    } alu_opcode_e;

endpackage

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid_ip,
    output logic                  req0_ready_op,
    input  alu_opcode_e           req0_operator_ip,
    input  logic [DATA_WIDTH-1:0] req0_operand_a_ip,
    input  logic [DATA_WIDTH-1:0] req0_operand_b_ip,
    output logic                  rsp0_valid_op,
    input  logic                  rsp0_ready_ip,
    output logic [DATA_WIDTH-1:0] rsp0_result_op,
    output logic                  rsp0_error_op,

    input  logic                  req1_valid_ip,
    output logic                  req1_ready_op,
    input  alu_opcode_e           req1_operator_ip,
    input  logic [DATA_WIDTH-1:0] req1_operand_a_ip,
    input  logic [DATA_WIDTH-1:0] req1_operand_b_ip,
    output logic                  rsp1_valid_op,
    input  logic                  rsp1_ready_ip,
    output logic [DATA_WIDTH-1:0] rsp1_result_op,
    output logic                  rsp1_error_op,

    output logic                  alu_enable_op,
    output alu_opcode_e           alu_operator_op,
    output logic [DATA_WIDTH-1:0] alu_operand_a_op,
    output logic [DATA_WIDTH-1:0] alu_operand_b_op,
    input  logic [DATA_WIDTH-1:0] alu_result_ip,
    input  logic                  alu_valid_ip
);

    // last_grant = 1 means requester 1 was served most recently
    logic last_grant;
    logic free0, free1;
    logic elig0, elig1;
    logic grant0, grant1;

    always_comb begin
        free0  = !rsp0_valid_op || rsp0_ready_ip;
        free1  = !rsp1_valid_op || rsp1_ready_ip;
        elig0  = req0_valid_ip && free0;
        elig1  = req1_valid_ip && free1;
        // reset gating keeps ready and enable low while reset is held
        grant0 = !reset && elig0 && (!elig1 || last_grant);
        grant1 = !reset && elig1 && (!elig0 || !last_grant);
    end

    assign req0_ready_op = grant0;
    assign req1_ready_op = grant1;

    always_comb begin
        alu_enable_op    = 1'b0;
        alu_operator_op  = ALU_ADD;
        alu_operand_a_op = '0;
        alu_operand_b_op = '0;
        if (grant0) begin
            alu_enable_op    = 1'b1;
            alu_operator_op  = req0_operator_ip;
            alu_operand_a_op = req0_operand_a_ip;
            alu_operand_b_op = req0_operand_b_ip;
        end else if (grant1) begin
            alu_enable_op    = 1'b1;
            alu_operator_op  = req1_operator_ip;
            alu_operand_a_op = req1_operand_a_ip;
            alu_operand_b_op = req1_operand_b_ip;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // A refill takes priority over a drain at the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid_op  <= 1'b0;
            rsp0_result_op <= '0;
            rsp0_error_op  <= 1'b0;
        end else if (grant0) begin
            rsp0_valid_op  <= 1'b1;
            rsp0_result_op <= alu_result_ip;
            rsp0_error_op  <= !alu_valid_ip;
        end else if (rsp0_ready_ip) begin
            rsp0_valid_op  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp1_valid_op  <= 1'b0;
            rsp1_result_op <= '0;
            rsp1_error_op  <= 1'b0;
        end else if (grant1) begin
            rsp1_valid_op  <= 1'b1;
            rsp1_result_op <= alu_result_ip;
            rsp1_error_op  <= !alu_valid_ip;
        end else if (rsp1_ready_ip) begin
            rsp1_valid_op  <= 1'b0;
        end
    end

endmodule
